predelay_commutator: RTL and testbench

PREDELAY_COMMUTATOR -- requirements
Module: predelay_commutator

---
 rtl/predelay_commutator_pkg.sv | 20 ++
 rtl/delay_line.sv | 48 ++++
 rtl/predelay_commutator.sv | 125 ++++++++++++
 tb/tb_predelay_commutator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/predelay_commutator_pkg.sv
// Shared FFT datapath definitions: sample/counter widths, default frame
// geometry and the complex sample word used by the commutator, the
// post-delay stage and the butterfly stage.
package predelay_commutator_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    localparam int DEF_DELAY_CYCLES        = 16;
    localparam int DEF_NUM_INPUTS_PER_PATH = 32;

    // re in the upper half, im in the lower half of the 32-bit word
    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    localparam int CPLX_W = $bits(cplx_t);

endpackage

// File: rtl/delay_line.sv
// Circular buffer of DEPTH complex words. The read port returns the entry
// at the write pointer, i.e. the word written DEPTH writes ago, before the
// current write replaces it. Contents are deliberately not reset.
module delay_line #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;

    // pointer advances only on writes so bubbles never age the contents
    always_comb begin
        ptr_d = ptr_q;
        if (we) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    // write pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // storage array, no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[ptr_q];

endmodule

// File: rtl/predelay_commutator.sv
// Pre-delay and commutator: path 1 is delayed by DELAY_CYCLES accepted
// samples, then the two paths are swapped every DELAY_CYCLES samples so
// the post-delay stage sees the pairs in butterfly order.
module predelay_commutator
    import predelay_commutator_pkg::*;
#(
    parameter int DELAY_CYCLES        = DEF_DELAY_CYCLES,
    parameter int NUM_INPUTS_PER_PATH = DEF_NUM_INPUTS_PER_PATH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in0_re,
    input  logic [DATA_W-1:0] in0_im,
    input  logic [DATA_W-1:0] in1_re,
    input  logic [DATA_W-1:0] in1_im,
    output logic [DATA_W-1:0] cm_out0_re,
    output logic [DATA_W-1:0] cm_out0_im,
    output logic [DATA_W-1:0] cm_out1_re,
    output logic [DATA_W-1:0] cm_out1_im,
    output logic              out_valid,
    output logic [CNT_W-1:0]  cntr_IFFT_input_pairs,
    output logic              frame_done
);

    localparam int SWAP_BIT = $clog2(DELAY_CYCLES);
    localparam logic [CNT_W-1:0] K_LAST     = CNT_W'(NUM_INPUTS_PER_PATH - 1);
    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(DELAY_CYCLES - 1);

    cplx_t in0_c;
    cplx_t in1_c;
    cplx_t d1_c;

    logic [CNT_W-1:0] k_q, k_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] oidx_q, oidx_d;
    cplx_t            out0_q, out0_d;
    cplx_t            out1_q, out1_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fd_q, fd_d;
    logic             fire;

    assign in0_c = '{re: in0_re, im: in0_im};
    assign in1_c = '{re: in1_re, im: in1_im};

    delay_line #(
        .DEPTH  (DELAY_CYCLES),
        .WORD_W (CPLX_W)
    ) u_delay_line (
        .clk     (CLK),
        .rst     (RST),
        .we      (in_valid),
        .wr_data (in1_c),
        .rd_data (d1_c)
    );

    // input counter, priming, output index and commutator routing
    always_comb begin
        k_d      = k_q;
        primed_d = primed_q;
        oidx_d   = oidx_q;
        out0_d   = out0_q;
        out1_d   = out1_q;
        valid_d  = 1'b0;
        cnt_d    = cnt_q;
        fd_d     = 1'b0;
        // primed_q is the pre-write value, so the pair that completes
        // priming still produces no output
        fire     = in_valid & primed_q;

        if (in_valid) begin
            k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
            if (k_q == PRIME_LAST) begin
                primed_d = 1'b1;
            end
        end

        if (fire) begin
            valid_d = 1'b1;
            cnt_d   = oidx_q;
            fd_d    = (oidx_q == K_LAST);
            oidx_d  = (oidx_q == K_LAST) ? '0 : oidx_q + 1'b1;
            if (k_q[SWAP_BIT]) begin
                out0_d = d1_c;
                out1_d = in0_c;
            end else begin
                out0_d = in0_c;
                out1_d = d1_c;
            end
        end
    end

    // state and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k_q      <= '0;
            primed_q <= 1'b0;
            oidx_q   <= '0;
            out0_q   <= '0;
            out1_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            fd_q     <= 1'b0;
        end else begin
            k_q      <= k_d;
            primed_q <= primed_d;
            oidx_q   <= oidx_d;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            fd_q     <= fd_d;
        end
    end

    assign cm_out0_re            = out0_q.re;
    assign cm_out0_im            = out0_q.im;
    assign cm_out1_re            = out1_q.re;
    assign cm_out1_im            = out1_q.im;
    assign out_valid             = valid_q;
    assign cntr_IFFT_input_pairs = cnt_q;
    assign frame_done            = fd_q;

endmodule

// File: tb/tb_predelay_commutator.sv
// Bench for predelay_commutator: directed ramp sequence followed by random
// traffic with bubbles and resets, compared against a sample-history model.
module tb_predelay_commutator;
    import predelay_commutator_pkg::*;

    localparam int D = 16;
    localparam int N = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              in_valid;
    logic [DATA_W-1:0] in0_re, in0_im, in1_re, in1_im;
    logic [DATA_W-1:0] cm_out0_re, cm_out0_im, cm_out1_re, cm_out1_im;
    logic              out_valid;
    logic [CNT_W-1:0]  cntr_IFFT_input_pairs;
    logic              frame_done;

    predelay_commutator #(
        .DELAY_CYCLES        (D),
        .NUM_INPUTS_PER_PATH (N)
    ) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .in_valid              (in_valid),
        .in0_re                (in0_re),
        .in0_im                (in0_im),
        .in1_re                (in1_re),
        .in1_im                (in1_im),
        .cm_out0_re            (cm_out0_re),
        .cm_out0_im            (cm_out0_im),
        .cm_out1_re            (cm_out1_re),
        .cm_out1_im            (cm_out1_im),
        .out_valid             (out_valid),
        .cntr_IFFT_input_pairs (cntr_IFFT_input_pairs),
        .frame_done            (frame_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // model: every in1 accepted since reset, plus expected output registers
    int          acc;
    logic [15:0] hist_re[$];
    logic [15:0] hist_im[$];
    logic        e_valid, e_fd;
    logic [15:0] e0re, e0im, e1re, e1im;
    logic [4:0]  e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        acc = 0;
        hist_re.delete();
        hist_im.delete();
        e_valid = 1'b0;
        e_fd    = 1'b0;
        e0re = '0; e0im = '0; e1re = '0; e1im = '0;
        e_cnt = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid",  32'(out_valid),  32'(e_valid));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("out0_re",    32'(cm_out0_re), 32'(e0re));
        chk("out0_im",    32'(cm_out0_im), 32'(e0im));
        chk("out1_re",    32'(cm_out1_re), 32'(e1re));
        chk("out1_im",    32'(cm_out1_im), 32'(e1im));
        if (e_valid) begin
            chk("cntr", 32'(cntr_IFFT_input_pairs), 32'(e_cnt));
        end
    endtask

    // one clock: apply inputs, step past the edge, update model, compare
    task automatic drive_cycle(input logic v, input logic [15:0] a_re, input logic [15:0] a_im,
                               input logic [15:0] b_re, input logic [15:0] b_im);
        int k;
        logic [15:0] d_re, d_im;
        in_valid = v;
        in0_re = a_re; in0_im = a_im;
        in1_re = b_re; in1_im = b_im;
        @(posedge CLK);
        #1;
        e_valid = 1'b0;
        e_fd    = 1'b0;
        if (v) begin
            if (acc >= D) begin
                k    = acc % N;
                d_re = hist_re[acc - D];
                d_im = hist_im[acc - D];
                e_valid = 1'b1;
                if (((k / D) % 2) == 1) begin
                    e0re = d_re; e0im = d_im; e1re = a_re; e1im = a_im;
                end else begin
                    e0re = a_re; e0im = a_im; e1re = d_re; e1im = d_im;
                end
                e_cnt = 5'((acc - D) % N);
                e_fd  = (e_cnt == 5'(N - 1));
            end
            hist_re.push_back(b_re);
            hist_im.push_back(b_im);
            acc++;
        end
        check_outputs();
    endtask

    // reset asserted between clock edges; outputs must clear without a clock
    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cntr",      32'(cntr_IFFT_input_pairs), 32'd0);
        check_outputs();
        #1;
        RST = 1'b0;
    endtask

    task automatic ramp_pair(input int n);
        drive_cycle(1'b1, 16'(n), 16'(-n), 16'(1000 + n), 16'(-(1000 + n)));
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b0;
        in0_re = '0; in0_im = '0; in1_re = '0; in1_im = '0;
        model_reset();
        #12;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_out0",  32'(cm_out0_re), 32'd0);
        RST = 1'b0;

        // directed ramp: in0 = n, in1 = 1000 + n, im = -re
        for (int n = 0; n <= 50; n++) begin
            ramp_pair(n);
            if (n == 16) begin
                chk("n16_out0_re", 32'(cm_out0_re), 32'd1000);
                chk("n16_out1_re", 32'(cm_out1_re), 32'd16);
                chk("n16_out1_im", 32'(cm_out1_im), 32'(16'hFFF0));
                chk("n16_cntr",    32'(cntr_IFFT_input_pairs), 32'd0);
            end
            if (n == 21) begin
                chk("n21_out0_re", 32'(cm_out0_re), 32'd1005);
                chk("n21_out1_re", 32'(cm_out1_re), 32'd21);
                chk("n21_cntr",    32'(cntr_IFFT_input_pairs), 32'd5);
            end
            if (n == 32) begin
                chk("n32_out0_re", 32'(cm_out0_re), 32'd32);
                chk("n32_out1_re", 32'(cm_out1_re), 32'd1016);
                chk("n32_cntr",    32'(cntr_IFFT_input_pairs), 32'd16);
            end
            if (n == 47) begin
                chk("n47_cntr", 32'(cntr_IFFT_input_pairs), 32'd31);
                chk("n47_fd",   32'(frame_done), 32'd1);
            end
            if (n == 48) begin
                chk("n48_cntr", 32'(cntr_IFFT_input_pairs), 32'd0);
                chk("n48_fd",   32'(frame_done), 32'd0);
            end
            if (n == 20) begin
                for (int b = 0; b < 3; b++) begin
                    drive_cycle(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                    chk("bubble_valid", 32'(out_valid), 32'd0);
                    chk("bubble_hold",  32'(cm_out0_re), 32'd1004);
                end
            end
        end

        // mid-frame reset, then re-prime with fresh values
        async_reset();
        for (int j = 0; j <= D; j++) begin
            drive_cycle(1'b1, 16'(3000 + j), 16'(-(3000 + j)), 16'(2000 + j), 16'(-(2000 + j)));
            if (j < D) begin
                chk("reprime_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("reprime_out0", 32'(cm_out0_re), 32'd2000);
                chk("reprime_valid1", 32'(out_valid), 32'd1);
            end
        end

        // random traffic with bubbles and occasional resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                drive_cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                            16'($urandom), 16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
